// File: rtl/key_game_sequencer.sv
// Two-player key race controller: edge-detects start and player keys, arbitrates
// ties round-robin, drives the press counter's keyPress/gameStart, scores and picks a winner.
module key_game_sequencer #(
    parameter int unsigned WIN_SCORE = 3,
    parameter int unsigned LOCKOUT   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       startBtn,
    input  logic       keyA,
    input  logic       keyB,
    output logic       gameStart,
    output logic       keyPress,
    output logic       player,
    output logic [2:0] scoreA,
    output logic [2:0] scoreB,
    output logic [1:0] winner
);

    localparam int unsigned SCORE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   LOCK_VAL = CNT_W'(LOCKOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        WIN  = 2'd3
    } state_t;

    state_t             state;
    logic               start_q;
    logic               keya_q;
    logic               keyb_q;
    logic               last_grant;
    logic [CNT_W-1:0]   lock_cnt;

    logic               start_e;
    logic               a_e;
    logic               b_e;
    logic               grant_any;
    logic               grant_b;
    logic [SCORE_W-1:0] next_score;

    // Rising-edge detection and grant arbitration (tie goes to the player opposite the last grant)
    always_comb begin
        start_e    = startBtn & ~start_q;
        a_e        = keyA & ~keya_q;
        b_e        = keyB & ~keyb_q;
        grant_any  = a_e | b_e;
        grant_b    = (a_e & b_e) ? ~last_grant : b_e;
        next_score = (grant_b ? scoreB : scoreA) + SCORE_W'(1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            gameStart  <= 1'b0;
            keyPress   <= 1'b0;
            player     <= 1'b0;
            scoreA     <= '0;
            scoreB     <= '0;
            winner     <= 2'b00;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
            // Inputs held through reset must be released before they count as an edge
            start_q    <= 1'b1;
            keya_q     <= 1'b1;
            keyb_q     <= 1'b1;
        end else begin
            start_q  <= startBtn;
            keya_q   <= keyA;
            keyb_q   <= keyB;
            keyPress <= 1'b0;

            case (state)
                IDLE, WIN: begin
                    if (start_e) begin
                        state      <= PLAY;
                        gameStart  <= 1'b1;
                        scoreA     <= '0;
                        scoreB     <= '0;
                        winner     <= 2'b00;
                        last_grant <= 1'b1;
                    end
                end

                PLAY: begin
                    if (grant_any) begin
                        keyPress   <= 1'b1;
                        player     <= grant_b;
                        last_grant <= grant_b;
                        if (grant_b) scoreB <= next_score;
                        else         scoreA <= next_score;

                        if (next_score == WIN_VAL) begin
                            state     <= WIN;
                            gameStart <= 1'b0;
                            lock_cnt  <= '0;
                            winner    <= grant_b ? 2'b10 : 2'b01;
                        end else begin
                            state    <= HOLD;
                            lock_cnt <= LOCK_VAL;
                        end
                    end
                end

                // Stay exactly LOCKOUT cycles, ignoring key edges
                HOLD: begin
                    if (lock_cnt <= CNT_W'(1)) begin
                        state    <= PLAY;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_game_sequencer.sv
// Self-checking bench for key_game_sequencer: directed scenarios plus a randomized run
// against a cycle-indexed behavioural model of the game rules.
module tb_key_game_sequencer;

    localparam int unsigned WIN_SCORE = 3;
    localparam int unsigned LOCKOUT   = 4;

    logic       Clock;
    logic       Reset;
    logic       startBtn;
    logic       keyA;
    logic       keyB;
    logic       gameStart;
    logic       keyPress;
    logic       player;
    logic [2:0] scoreA;
    logic [2:0] scoreB;
    logic [1:0] winner;

    int n_tests = 0;
    int n_fail  = 0;

    key_game_sequencer #(.WIN_SCORE(WIN_SCORE), .LOCKOUT(LOCKOUT)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .startBtn (startBtn),
        .keyA     (keyA),
        .keyB     (keyB),
        .gameStart(gameStart),
        .keyPress (keyPress),
        .player   (player),
        .scoreA   (scoreA),
        .scoreB   (scoreB),
        .winner   (winner)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Game model: 0 idle, 1 in play, 2 won. Lockout tracked as the first cycle a grant is allowed.
    int   m_game;
    int   m_score[2];
    int   m_winner;
    int   m_player;
    int   m_kp;
    int   m_gs;
    int   m_last;
    int   m_next_ok;
    int   cyc;
    logic m_sp, m_ap, m_bp;

    function automatic logic [10:0] exp_vec();
        return {1'(m_gs), 1'(m_kp), 1'(m_player), 3'(m_score[0]), 3'(m_score[1]), 2'(m_winner)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {gameStart, keyPress, player, scoreA, scoreB, winner};
    endfunction

    task automatic step_rst(input logic s, input logic a, input logic b);
        Reset = 1'b1; startBtn = s; keyA = a; keyB = b;
        m_game = 0; m_score[0] = 0; m_score[1] = 0; m_winner = 0; m_player = 0;
        m_kp = 0; m_gs = 0; m_last = 1; m_next_ok = 0;
        m_sp = 1'b1; m_ap = 1'b1; m_bp = 1'b1;
        cyc++;
        @(posedge Clock); #1;
    endtask

    task automatic step(input logic s, input logic a, input logic b);
        logic se, ae, be;
        int   g;
        Reset = 1'b0; startBtn = s; keyA = a; keyB = b;
        se = s & ~m_sp; ae = a & ~m_ap; be = b & ~m_bp;
        m_kp = 0;
        if (m_game != 1) begin
            if (se) begin
                m_game = 1; m_score[0] = 0; m_score[1] = 0; m_winner = 0;
                m_last = 1; m_gs = 1; m_next_ok = cyc + 1;
            end
        end else if (cyc >= m_next_ok && (ae || be)) begin
            g = (ae && be) ? 1 - m_last : (be ? 1 : 0);
            m_score[g]++;
            m_kp = 1; m_player = g; m_last = g;
            if (m_score[g] == int'(WIN_SCORE)) begin
                m_game = 2; m_gs = 0; m_winner = g + 1;
            end else begin
                m_next_ok = cyc + int'(LOCKOUT) + 1;
            end
        end
        m_sp = s; m_ap = a; m_bp = b;
        cyc++;
        @(posedge Clock); #1;
    endtask

    task automatic start_game();
        step_rst(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step_rst(1'b0, 1'b0, 1'b0);
        step_rst(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 11'd0);
        end
    endtask

    task automatic test_startup();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (gameStart !== 1'b1 || scoreA !== 3'd0 || scoreB !== 3'd0 || winner !== 2'b00) begin
            n_fail++; $display("FAIL startup: got %h expected gs=1 scores 0 winner 0", dut_vec());
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL startup_model: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single_press();
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (keyPress !== 1'b1 || player !== 1'b0 || scoreA !== 3'd1) begin
            n_fail++; $display("FAIL single_press: got %h expected kp=1 player=0 scoreA=1", dut_vec());
        end
        for (int i = 0; i < int'(LOCKOUT); i++) begin
            step(1'b0, 1'b1, 1'(i % 2 == 0));
            n_tests++;
            if (keyPress !== 1'b0 || scoreB !== 3'd0 || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL lockout_ignore[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_tie();
        logic [2:0] exp_player;
        exp_player = 3'b010;
        start_game();
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (keyPress !== 1'b1 || player !== exp_player[t]) begin
                n_fail++; $display("FAIL tie_grant[%0d]: got kp=%b player=%b expected kp=1 player=%b",
                                   t, keyPress, player, exp_player[t]);
            end
            for (int i = 0; i < int'(LOCKOUT); i++) step(1'b0, 1'b0, 1'b0);
        end
        n_tests++;
        if (scoreA !== 3'd2 || scoreB !== 3'd1) begin
            n_fail++; $display("FAIL tie_scores: got A=%0d B=%0d expected A=2 B=1", scoreA, scoreB);
        end
    endtask

    task automatic test_held_key();
        int kp_seen;
        start_game();
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (keyPress !== 1'b1 || player !== 1'b1 || scoreB !== 3'd1) begin
            n_fail++; $display("FAIL held_first: got %h expected kp=1 player=1 scoreB=1", dut_vec());
        end
        kp_seen = 0;
        for (int i = 0; i < int'(LOCKOUT) + 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            kp_seen += int'(keyPress);
        end
        n_tests++;
        if (kp_seen != 0 || scoreB !== 3'd1) begin
            n_fail++; $display("FAIL held_no_regrant: got %0d pulses scoreB=%0d expected 0 pulses scoreB=1",
                               kp_seen, scoreB);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (keyPress !== 1'b1 || scoreB !== 3'd2) begin
            n_fail++; $display("FAIL held_repress: got kp=%b scoreB=%0d expected kp=1 scoreB=2", keyPress, scoreB);
        end
    endtask

    task automatic test_win();
        start_game();
        for (int g = 0; g < int'(WIN_SCORE) - 1; g++) begin
            step(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < int'(LOCKOUT); i++) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (keyPress !== 1'b1 || gameStart !== 1'b0 || winner !== 2'b01 || scoreA !== 3'(WIN_SCORE)) begin
            n_fail++; $display("FAIL win_grant: got %h expected kp=1 gs=0 winner=01 scoreA=%0d", dut_vec(), WIN_SCORE);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2 == 1), 1'(i % 2 == 1));
        n_tests++;
        if (keyPress !== 1'b0 || winner !== 2'b01 || scoreA !== 3'(WIN_SCORE) || scoreB !== 3'd0) begin
            n_fail++; $display("FAIL win_hold: got %h expected winner=01 scores held", dut_vec());
        end
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (gameStart !== 1'b1 || winner !== 2'b00 || scoreA !== 3'd0 || scoreB !== 3'd0) begin
            n_fail++; $display("FAIL win_restart: got %h expected gs=1 scores 0 winner 0", dut_vec());
        end
    endtask

    task automatic test_midgame_reset();
        start_game();
        step_rst(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (keyPress !== 1'b0 || dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_vs_grant: got %h expected %h", dut_vec(), 11'd0);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < int'(LOCKOUT); i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (scoreB !== 3'd2 || gameStart !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_state: got scoreB=%0d gs=%b expected scoreB=2 gs=1", scoreB, gameStart);
        end
        step_rst(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL midhold_reset: got %h expected %h", dut_vec(), 11'd0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (gameStart !== 1'b0) begin
            n_fail++; $display("FAIL held_start_ignored: got gs=%b expected 0", gameStart);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (gameStart !== 1'b1) begin
            n_fail++; $display("FAIL repress_start: got gs=%b expected 1", gameStart);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        start_game();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step_rst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            end
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs <= 10) $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        cyc = 0;
        Reset = 1'b1; startBtn = 1'b0; keyA = 1'b0; keyB = 1'b0;
        test_reset();
        test_startup();
        test_single_press();
        test_tie();
        test_held_key();
        test_win();
        test_midgame_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_game_sequencer.md
Name: key_game_sequencer

Overview:
- Game controller that sequences the 2-bit hex-selector press counter for a two-player key race.
- Edge-detects the start button and two player keys.
- Arbitrates simultaneous presses round-robin and generates the single-cycle keyPress pulse and the gameStart level that drive the counter.
- Keeps per-player scores, applies a post-press lockout, and declares a winner.

Parameters:
- WIN_SCORE, 3: score at which a player wins; legal range 1..7.
- LOCKOUT, 4: cycles after a granted press during which key edges are ignored; legal range 1..255.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- startBtn  input  1  start/restart button, already synchronized.
- keyA  input  1  player A key, already synchronized.
- keyB  input  1  player B key, already synchronized.
- gameStart  output  1  high while a game is in progress; feeds counter gameStart.
- keyPress  output  1  one-cycle pulse per granted press; feeds counter keyPress.
- player  output  1  owner of the most recent grant: 0 = A, 1 = B.
- scoreA  output  3  player A granted-press count.
- scoreB  output  3  player B granted-press count.
- winner  output  2  00 none, 01 A, 10 B.

Behaviour:
- All outputs are registered.
- Edge detect:
  - startE = startBtn & ~start_q; aE = keyA & ~keyA_q; bE = keyB & ~keyB_q.
  - The *_q registers sample their inputs every cycle, in every state.
  - On Reset the *_q registers load 1, so an input held through reset must be released and re-pressed.
- Reset: state=IDLE, gameStart=0, keyPress=0, player=0, scoreA=scoreB=0, winner=00, lastGrant=B, lockout counter=0.
- States:
  - IDLE: gameStart=0. On startE -> PLAY and clear scores, winner and lastGrant(=B); gameStart=1 from the next cycle. aE and bE are ignored.
  - PLAY: gameStart=1. Grant rules:
    - aE only -> grant A.
    - bE only -> grant B.
    - aE and bE in the same cycle -> grant the player opposite lastGrant; the other edge is dropped.
  - On a grant, at the same clock edge:
    - keyPress=1 for exactly the next cycle.
    - player and lastGrant set to the winner of the grant.
    - That player's score increments.
    - If the new score equals WIN_SCORE -> WIN; otherwise -> HOLD with lockout counter=LOCKOUT.
  - HOLD: gameStart=1. aE and bE are ignored. The counter decrements each cycle; leaving HOLD when it reaches 0 gives exactly LOCKOUT cycles in HOLD, then PLAY. A key held through HOLD does not produce a grant on return to PLAY.
  - WIN: gameStart=0 from the cycle after the winning grant, in the same cycle as the final keyPress pulse; the counter therefore clears. winner=01 or 10 and holds, scores hold, aE and bE are ignored. On startE -> PLAY with scores, winner and lastGrant cleared.
- startE in PLAY or HOLD is ignored.
- Latency: key edge visible in cycle N -> keyPress high in cycle N+1 only, with the score updated in cycle N+1.
- keyPress is never high for two consecutive cycles. At most one grant occurs per LOCKOUT+1 cycles.
- Scores never exceed WIN_SCORE and never wrap.
- Reset in any state, including mid-HOLD or in the same cycle as a grant, takes priority: next cycle shows reset values and no keyPress.

Test Plan:
- Start-up:
  - Stimulus: Reset 2 cycles, pulse startBtn.
  - Required: gameStart=0 until the cycle after the startE cycle, then 1; scores 0, winner 00.
- Single press:
  - Stimulus: in PLAY, keyA 0->1 in cycle N.
  - Required: keyPress=1 in cycle N+1 only, player=0, scoreA=1; keyB edges at N+1..N+4 ignored (LOCKOUT=4); scoreB stays 0.
- Tie round-robin:
  - Stimulus: keyA and keyB rise together three times, each separated by the lockout.
  - Required: grants A, B, A; scoreA=2, scoreB=1.
- Held key:
  - Stimulus: keyB held high across HOLD and back into PLAY.
  - Required: no second grant until keyB is released and re-pressed.
- Win:
  - Stimulus: WIN_SCORE=3; player A gets 3 grants.
  - Required: on the third grant, keyPress=1 and gameStart=0 in the same cycle; winner=01 holds; further keys have no effect; startBtn edge restarts with scores 0 and winner 00.
- Mid-game reset:
  - Stimulus: assert Reset during HOLD with scoreB=2.
  - Required: next cycle shows state IDLE, scores 0, gameStart=0, keyPress=0; startBtn held through reset must be re-pressed to start.
